// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, NOP encoding and fetch FSM states.
package pipe_pkg;
  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register. Flush has priority over load; with neither it holds,
// so stalled outputs are bit-stable. A flush leaves the PC fields untouched.
module ifid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    pc_plus1_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus1_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      instr_o    <= INSTR_W'(NOP_INSTR);
      pc_o       <= '0;
      pc_plus1_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_o <= INSTR_W'(NOP_INSTR);
    end else if (load_i) begin
      valid_o    <= 1'b1;
      instr_o    <= instr_i;
      pc_o       <= pc_i;
      pc_plus1_o <= pc_plus1_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, stall hold buffer and IF/ID register.
// Optional FETCH_STATS_EN adds saturating stall/flush cycle counters.
//
//  state | meaning
//  IDLE  | first cycle out of reset, no request
//  FETCH | request at pc
//  HOLD  | instruction acked under stall, parked in hold buffer
//  KILL  | redirected with request outstanding; wait for ack and drop data
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
`ifdef FETCH_STATS_EN
  output logic [15:0]        stat_stall_cnt_o,
  output logic [15:0]        stat_flush_cnt_o,
`endif
  output logic               ifid_valid_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [PC_W-1:0]    ifid_pc_plus1_o
);

  fetch_state_t       state_q;
  logic [PC_W-1:0]    pc_q, target_q, pc_plus1;
  logic [INSTR_W-1:0] hold_q, ld_instr;
  logic               req_q, ifid_load, ifid_flush;

  assign pc_plus1    = pc_q + PC_W'(1);
  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;

  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ld_instr   = imem_rdata_i;
    if (redirect_i) begin
      ifid_flush = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!stall_i && imem_ack_i)  ifid_load  = 1'b1;
          if (!stall_i && !imem_ack_i) ifid_flush = 1'b1;
        end
        ST_HOLD: begin
          ld_instr  = hold_q;
          ifid_load = !stall_i;
        end
        default: ;
      endcase
    end
  end

  // pc_q doubles as the fetch address, so in KILL it keeps the old address
  // and the redirect target waits in target_q until the ack arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      target_q <= '0;
      hold_q   <= INSTR_W'(NOP_INSTR);
      req_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_i) pc_q <= redirect_pc_i;
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (redirect_i) begin
            if (imem_ack_i) begin
              pc_q <= redirect_pc_i;
            end else begin
              target_q <= redirect_pc_i;
              state_q  <= ST_KILL;
            end
          end else if (imem_ack_i && !stall_i) begin
            pc_q <= pc_plus1;
          end else if (imem_ack_i) begin
            hold_q  <= imem_rdata_i;
            state_q <= ST_HOLD;
            req_q   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redirect_i || !stall_i) begin
            pc_q    <= redirect_i ? redirect_pc_i : pc_plus1;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        ST_KILL: begin
          if (imem_ack_i) begin
            pc_q    <= redirect_i ? redirect_pc_i : target_q;
            state_q <= ST_FETCH;
          end else if (redirect_i) begin
            target_q <= redirect_pc_i;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ifid_pipe_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .instr_i    (ld_instr),
    .pc_i       (pc_q),
    .pc_plus1_i (pc_plus1),
    .valid_o    (ifid_valid_o),
    .instr_o    (ifid_instr_o),
    .pc_o       (ifid_pc_o),
    .pc_plus1_o (ifid_pc_plus1_o)
  );

`ifdef FETCH_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_i && stall_cnt_q != 16'hFFFF)    stall_cnt_q <= stall_cnt_q + 16'd1;
      if (redirect_i && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stat_stall_cnt_o = stall_cnt_q;
  assign stat_flush_cnt_o = flush_cnt_q;
`endif

endmodule
